multicycle_divider: RTL and testbench

Parametrised radix-2 restoring integer divider. It computes quotient and remainder over WIDTH iterations and supports both unsigned and signed operands, selected per operation. Operands enter and results leave through valid/ready handshakes. It is the iterative successor to the single-cycle and pipelined arithmetic units in the multicycle_division example, and it sits behind the same operand-driving bench style.

---
 rtl/multicycle_divider.sv | 132 +++++++++++++
 tb/tb_multicycle_divider.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_divider.sv
// Radix-2 restoring integer divider: one quotient bit per clock, WIDTH iterations,
// unsigned or two's-complement operands per operation, valid/ready on both sides.
module multicycle_divider #(
  parameter int WIDTH     = 64,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dvs_mag;
  logic             neg_q;
  logic             neg_r;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + ONE) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

  logic             signed_op;
  logic             accept;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;

  assign signed_op = signed_mode & SIGNED_EN;
  assign accept    = in_valid & in_ready;

  // The quotient bits are shifted into the vacated low end of the dividend register.
  assign rem_shift = {rem_acc, dvd_sh[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_mag};
  assign q_bit     = ~trial[WIDTH];
  assign rem_next  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign q_next    = {dvd_sh[WIDTH-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (accept) begin
      rem_acc <= '0;
      dvd_sh  <= magnitude(dividend, signed_op);
      dvs_mag <= magnitude(divisor, signed_op);
      neg_q   <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r   <= signed_op & dividend[WIDTH-1];
    end else if (state == CALC) begin
      rem_acc <= rem_next;
      dvd_sh  <= q_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            cnt      <= '0;
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          // Sign correction is folded into the last iteration so DONE follows directly.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= apply_sign(q_next, neg_q);
            remainder   <= apply_sign(rem_next, neg_r);
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_divider.sv
// Scoreboard bench for multicycle_divider: an 8-bit and a 64-bit instance share
// clock and reset; stimulus pushes expected results, per-instance monitors check them.
module tb_multicycle_divider;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  logic rand_rdy = 1'b0;

  logic       iv8 = 1'b0, sm8 = 1'b0, ir8, ov8, or8, dz8, busy8;
  logic [7:0] a8 = '0, b8 = '0, q8, r8;

  logic        iv64 = 1'b0, sm64 = 1'b0, ir64, ov64, or64 = 1'b1, dz64, busy64;
  logic [63:0] a64 = '0, b64 = '0, q64, r64;

  exp_t sb8[$];
  exp_t sb64[$];
  int   acc8[$];
  int   acc64[$];

  assign or8 = 1'b1;

  multicycle_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .dividend(a8), .divisor(b8), .signed_mode(sm8),
    .out_valid(ov8), .out_ready(or8), .quotient(q8), .remainder(r8),
    .div_by_zero(dz8), .busy(busy8)
  );

  multicycle_divider #(.WIDTH(64), .SIGNED_EN(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
    .dividend(a64), .divisor(b64), .signed_mode(sm64),
    .out_valid(ov64), .out_ready(or64), .quotient(q64), .remainder(r64),
    .div_by_zero(dz64), .busy(busy64)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    or64 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // 8-bit monitor
  logic       pov8 = 1'b0, stall8 = 1'b0, hd8 = 1'b0;
  logic [7:0] hq8 = '0, hr8 = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc8.delete();
      pov8 = 1'b0;
      stall8 = 1'b0;
    end else begin
      if (iv8 && ir8) acc8.push_back(cyc);
      if (ov8 && !pov8) begin
        if (sb8.size() == 0 || acc8.size() == 0) chk("unexpected_valid8", 1, 0);
        else chk("latency8", 64'(cyc - acc8.pop_front()), 64'(sb8[0].lat));
      end
      if (ov8 && stall8) begin
        chk("stable_q8", 64'(q8), 64'(hq8));
        chk("stable_r8", 64'(r8), 64'(hr8));
        chk("stable_dz8", 64'(dz8), 64'(hd8));
      end
      if (ov8 && or8 && sb8.size() != 0) begin
        chk("quotient8", 64'(q8), sb8[0].q);
        chk("remainder8", 64'(r8), sb8[0].r);
        chk("div_by_zero8", 64'(dz8), 64'(sb8[0].dz));
        void'(sb8.pop_front());
      end
      hq8 = q8; hr8 = r8; hd8 = dz8;
      stall8 = ov8 && !or8;
      pov8 = ov8;
    end
  end

  // 64-bit monitor
  logic        pov64 = 1'b0, stall64 = 1'b0, hd64 = 1'b0;
  logic [63:0] hq64 = '0, hr64 = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc64.delete();
      pov64 = 1'b0;
      stall64 = 1'b0;
    end else begin
      if (iv64 && ir64) acc64.push_back(cyc);
      if (ov64 && !pov64) begin
        if (sb64.size() == 0 || acc64.size() == 0) chk("unexpected_valid64", 1, 0);
        else chk("latency64", 64'(cyc - acc64.pop_front()), 64'(sb64[0].lat));
      end
      if (ov64 && stall64) begin
        chk("stable_q64", q64, hq64);
        chk("stable_r64", r64, hr64);
        chk("stable_dz64", 64'(dz64), 64'(hd64));
      end
      if (ov64 && or64 && sb64.size() != 0) begin
        chk("quotient64", q64, sb64[0].q);
        chk("remainder64", r64, sb64[0].r);
        chk("div_by_zero64", 64'(dz64), 64'(sb64[0].dz));
        void'(sb64.pop_front());
      end
      hq64 = q64; hr64 = r64; hd64 = dz64;
      stall64 = ov64 && !or64;
      pov64 = ov64;
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input logic [7:0] eq, input logic [7:0] er, input logic ed,
                        input int lat);
    exp_t e;
    int n;
    e.q = 64'(eq); e.r = 64'(er); e.dz = ed; e.lat = lat;
    sb8.push_back(e);
    @(posedge clk); #1;
    iv8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
    n = 0;
    @(negedge clk);
    while (!ir8 && n < 500) begin @(negedge clk); n++; end
    if (!ir8) chk("accept8_timeout", 0, 1);
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'h5A; b8 = 8'h00; sm8 = ~sm;
  endtask

  task automatic issue64(input logic [63:0] a, input logic [63:0] b, input logic sm,
                         input logic [63:0] eq, input logic [63:0] er, input logic ed,
                         input int lat, input bit push);
    exp_t e;
    int n;
    e.q = eq; e.r = er; e.dz = ed; e.lat = lat;
    if (push) sb64.push_back(e);
    @(posedge clk); #1;
    iv64 = 1'b1; a64 = a; b64 = b; sm64 = sm;
    n = 0;
    @(negedge clk);
    while (!ir64 && n < 2000) begin @(negedge clk); n++; end
    if (!ir64) chk("accept64_timeout", 0, 1);
    @(posedge clk); #1;
    iv64 = 1'b0; a64 = 64'hDEAD_BEEF_0BAD_F00D; b64 = '0; sm64 = ~sm;
  endtask

  task automatic drain8();
    int n = 0;
    while (sb8.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("drain8_pending", 64'(sb8.size()), 0);
  endtask

  task automatic drain64();
    int n = 0;
    while (sb64.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    chk("drain64_pending", 64'(sb64.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("rst_in_ready8", 64'(ir8), 0);
    chk("rst_out_valid8", 64'(ov8), 0);
    chk("rst_quotient8", 64'(q8), 0);
    chk("rst_remainder8", 64'(r8), 0);
    chk("rst_div_by_zero8", 64'(dz8), 0);
    chk("rst_busy8", 64'(busy8), 0);
    chk("rst_in_ready64", 64'(ir64), 0);
    chk("rst_out_valid64", 64'(ov64), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready8", 64'(ir8), 1);
    chk("release_in_ready64", 64'(ir64), 1);

    // unsigned 200/7
    issue8(8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 9);
    drain8();
    @(negedge clk);
    chk("in_ready_after_done8", 64'(ir8), 1);

    // signed truncating division with mixed signs, then overflow case in both modes
    issue8(8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 9);
    issue8(8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, 9);
    issue8(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 9);
    issue8(8'h80, 8'hFF, 1'b0, 8'h00, 8'h80, 1'b0, 9);
    issue8(8'h85, 8'h00, 1'b1, 8'hFF, 8'h85, 1'b1, 1);
    drain8();

    // divide by zero, both modes
    issue64(64'd12345, 64'd0, 1'b0, '1, 64'd12345, 1'b1, 1, 1'b1);
    issue64(64'd12345, 64'd0, 1'b1, '1, 64'd12345, 1'b1, 1, 1'b1);
    drain64();

    // random unsigned pairs with a stalling consumer
    rand_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ra = 64'($urandom) * 64'($urandom) + 64'($urandom);
      rb = 64'($urandom_range(1, 65535)) * 64'($urandom);
      if (i == 4) rb = 64'($urandom_range(2, 1000));
      if (rb == 0) rb = 64'd1;
      issue64(ra, rb, 1'b0, ra / rb, ra % rb, 1'b0, 65, 1'b1);
    end
    drain64();
    rand_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // abort an operation mid-calculation with reset
    issue64(64'd1000, 64'd3, 1'b0, 64'd333, 64'd1, 1'b0, 65, 1'b0);
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_in_ready64", 64'(ir64), 0);
    chk("abort_out_valid64", 64'(ov64), 0);
    chk("abort_busy64", 64'(busy64), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerelease_in_ready64", 64'(ir64), 1);
    repeat (80) @(negedge clk);
    chk("no_stale_valid64", 64'(ov64), 0);
    issue64(64'd100, 64'd10, 1'b0, 64'd10, 64'd0, 1'b0, 65, 1'b1);
    drain64();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
